// File: rtl/ro_scheduler_n.sv
// Multi-core readout scheduler: a binary/gray slot counter hands the shared bus to core k
// whenever gray bit k toggles. Define RO_OVERRUN_EN to add sticky per-core overrun flags.
module ro_scheduler_n #(
    parameter int NUM_CORES = 8,
    parameter int GC_WIDTH  = 19,
    parameter int DATA_W    = 2
) (
    input  logic                          clk_master,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_CORES*DATA_W-1:0]   in_data,
    output logic [DATA_W-1:0]             readout,
    output logic                          readout_valid,
    output logic [$clog2(NUM_CORES)-1:0]  readout_core,
    output logic [GC_WIDTH-1:0]           gray,
    output logic                          frame_start
`ifdef RO_OVERRUN_EN
    ,
    output logic [NUM_CORES-1:0]          overrun
`endif
);
    localparam int CW = $clog2(NUM_CORES);
    localparam int KW = $clog2(GC_WIDTH + 1);
    localparam logic [KW-1:0]       NC_K    = KW'(NUM_CORES);
    localparam logic [GC_WIDTH-1:0] BIN_MAX = {GC_WIDTH{1'b1}};

    generate
        if (GC_WIDTH < NUM_CORES + 1 || NUM_CORES < 2) begin : g_param_check
            $error("ro_scheduler_n: need NUM_CORES >= 2 and GC_WIDTH >= NUM_CORES+1");
        end
    endgenerate

    // The toggling gray bit is the trailing-ones count; the wrap toggles the MSB.
    function automatic logic [KW-1:0] trailing_ones(input logic [GC_WIDTH-1:0] b);
        logic [KW-1:0] cnt;
        logic          run;
        cnt = {KW{1'b0}};
        run = 1'b1;
        for (int i = 0; i < GC_WIDTH; i++) begin
            if (run && b[i]) begin
                cnt = cnt + KW'(1);
            end else begin
                run = 1'b0;
            end
        end
        if (cnt == KW'(GC_WIDTH)) begin
            cnt = KW'(GC_WIDTH - 1);
        end else begin
            cnt = cnt;
        end
        return cnt;
    endfunction

    logic [GC_WIDTH-1:0] bin_r;
    logic [GC_WIDTH-1:0] bin_next_s;
    logic [KW-1:0]       k_s;
    logic                slot_s;
    logic                wrap_s;
    logic [DATA_W-1:0]   sel_data_s;

    // Slot decode and data mux for the current counter value.
    always_comb begin
        bin_next_s = bin_r + GC_WIDTH'(1);
        k_s        = trailing_ones(bin_r);
        slot_s     = (k_s < NC_K);
        wrap_s     = (bin_r == BIN_MAX);
        sel_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            sel_data_s = (k_s == KW'(i)) ? in_data[i*DATA_W +: DATA_W] : sel_data_s;
        end
    end

    // Counter, gray code and readout bus registers.
    always_ff @(posedge clk_master) begin
        if (reset) begin
            bin_r         <= {GC_WIDTH{1'b0}};
            gray          <= {GC_WIDTH{1'b0}};
            readout       <= {DATA_W{1'b0}};
            readout_valid <= 1'b0;
            readout_core  <= {CW{1'b0}};
            frame_start   <= 1'b0;
        end else if (en) begin
            bin_r       <= bin_next_s;
            gray        <= bin_next_s ^ (bin_next_s >> 1'b1);
            frame_start <= wrap_s;
            if (slot_s) begin
                readout       <= sel_data_s;
                readout_valid <= 1'b1;
                readout_core  <= k_s[CW-1:0];
            end else begin
                readout       <= {DATA_W{1'b0}};
                readout_valid <= 1'b0;
            end
        end else begin
            readout       <= {DATA_W{1'b0}};
            readout_valid <= 1'b0;
            frame_start   <= 1'b0;
        end
    end

`ifdef RO_OVERRUN_EN
    logic [NUM_CORES*DATA_W-1:0] prev_r;
    logic [NUM_CORES-1:0]        pend_r;
    logic [NUM_CORES-1:0]        change_s;
    logic [NUM_CORES-1:0]        own_s;

    // Per-core change detect and slot ownership.
    always_comb begin
        change_s = {NUM_CORES{1'b0}};
        own_s    = {NUM_CORES{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            change_s[i] = (in_data[i*DATA_W +: DATA_W] != prev_r[i*DATA_W +: DATA_W]);
            own_s[i]    = slot_s && (k_s == KW'(i));
        end
    end

    // A second unread change before the core's slot is a lost sample.
    always_ff @(posedge clk_master) begin
        if (reset) begin
            prev_r  <= in_data;
            pend_r  <= {NUM_CORES{1'b0}};
            overrun <= {NUM_CORES{1'b0}};
        end else if (en) begin
            prev_r  <= in_data;
            pend_r  <= (pend_r | change_s) & ~own_s;
            overrun <= overrun | (pend_r & change_s & ~own_s);
        end else begin
            prev_r  <= prev_r;
            pend_r  <= pend_r;
            overrun <= overrun;
        end
    end
`endif

endmodule
